iterative_cipher_engine: RTL and testbench
==========================================

Name: iterative_cipher_engine

Overview:
Multi-round, clocked successor to the single-round XOR+rotate cipher. Each accepted block runs NUM_ROUNDS rounds, one round per clock, in either encrypt or decrypt mode. A per-round key schedule is derived from the supplied key. Valid/ready handshakes on input and output let it sit between a block source and a sink that may apply backpressure.

Parameters:
BLOCK_WIDTH, 32, data and key width in bits (>=8)
NUM_ROUNDS, 4, rounds per block (1..BLOCK_WIDTH)
ROT_AMT, 1, left-rotate amount per encrypt round (1..BLOCK_WIDTH-1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input block offered
in_ready  out  1  engine can accept a block
in_data  in  BLOCK_WIDTH  plaintext (encrypt) or ciphertext (decrypt)
in_key  in  BLOCK_WIDTH  base key
in_decrypt  in  1  0=encrypt, 1=decrypt; sampled with the block
out_valid  out  1  result available
out_ready  in  1  sink accepts result
out_data  out  BLOCK_WIDTH  result block
busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, round counter=0. Reset overrides all activity, including a block in flight; that block is discarded.
- Key schedule: K(r) = rotl(in_key, r mod BLOCK_WIDTH) for r = 0..NUM_ROUNDS-1. The key is registered at accept.
- Encrypt round r (r ascending 0..N-1): x <= rotl(x ^ K(r), ROT_AMT).
- Decrypt round r (r descending N-1..0): x <= rotr(x, ROT_AMT) ^ K(r). Decrypt exactly inverts encrypt for the same key and parameters.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch data, key and mode; counter=0; go to RUN.
  - RUN: in_ready=0. Apply one round per cycle. After round N-1 (counter==N-1), go to DONE and assert out_valid with the final value.
  - DONE: out_valid=1. out_data is held stable until out_ready. On out_valid&&out_ready, go to IDLE; out_valid drops next cycle.
- Latency: block accepted at edge T; out_valid high from edge T+NUM_ROUNDS. Minimum initiation interval is NUM_ROUNDS+2 cycles.
- in_ready is 0 in DONE. No same-cycle accept while a result is pending.
- in_data, in_key and in_decrypt changes after accept have no effect.
- in_valid held high while in_ready=0: the block is not taken; it is taken on return to IDLE.
- Rotations are modulo BLOCK_WIDTH. Round counter width is $clog2(NUM_ROUNDS+1).
- NUM_ROUNDS=1 special case: RUN lasts exactly one cycle.

Optional Feature:
Macro CIPHER_BLOCK_COUNT_EN.
- Defined: adds output port blocks_done (16 bits, reset 0). It increments by 1 on each out_valid&&out_ready handshake and wraps 0xFFFF->0x0000.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N=1, ROT=1, encrypt in_data=0x12345678, in_key=0xDEADBEEF -> out_data=0x9933D12F, out_valid 1 cycle after accept.
- N=1, ROT=1, encrypt 0x80000001, key 0 -> 0x00000003. Default N=4 with the same stimulus -> 0x00000018, out_valid exactly 4 cycles after accept.
- Default params: encrypt 0xCAFEF00D with key 0x0BADC0DE, then decrypt the result with the same key -> 0xCAFEF00D returned.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a second offered block is not accepted. Raise out_ready -> IDLE next cycle, second block accepted.
- Assert rst for 1 cycle mid-RUN (round 2 of 4) -> next cycle in_ready=1, out_valid=0, busy=0, and no output for the aborted block.
- CIPHER_BLOCK_COUNT_EN defined: 3 completed handshakes -> blocks_done=3. Preload to 0xFFFF by running blocks (or force) and complete one more -> 0x0000.

Source files
------------

// File: rtl/iterative_cipher_engine.sv
// iterative_cipher_engine
//
// Multi-round XOR+rotate block cipher. Each accepted block runs NUM_ROUNDS rounds, one round
// per clock, in encrypt or decrypt mode. The round key is the base key rotated left by the
// round index. Decrypt runs the rounds in reverse order and exactly inverts encrypt.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous, active-high reset; discards any block in flight
//   in_valid     input block offered
//   in_ready     engine can accept a block (IDLE only)
//   in_data      plaintext (encrypt) or ciphertext (decrypt)
//   in_key       base key
//   in_decrypt   0 = encrypt, 1 = decrypt; sampled with the block
//   out_valid    result available; held until out_ready
//   out_ready    sink accepts the result
//   out_data     result block, stable while out_valid is high
//   busy         high while a block is running or its result is pending
//   blocks_done  (only with CIPHER_BLOCK_COUNT_EN) 16-bit wrapping count of output handshakes
//
// Optional feature macro: CIPHER_BLOCK_COUNT_EN adds the blocks_done port and its counter.
//
// Timing: a block accepted at edge T gives out_valid from edge T+NUM_ROUNDS. The earliest
// next accept is at edge T+NUM_ROUNDS+2.

module iterative_cipher_engine #(
  parameter int unsigned BLOCK_WIDTH = 32,
  parameter int unsigned NUM_ROUNDS  = 4,
  parameter int unsigned ROT_AMT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLOCK_WIDTH-1:0] in_data,
  input  logic [BLOCK_WIDTH-1:0] in_key,
  input  logic                   in_decrypt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic                   busy
`ifdef CIPHER_BLOCK_COUNT_EN
  ,
  output logic [15:0]            blocks_done
`endif
);

  localparam int unsigned CntWidth = $clog2(NUM_ROUNDS + 1);
  localparam logic [CntWidth-1:0] LastRound = CntWidth'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                 state_q;
  logic [BLOCK_WIDTH-1:0] data_q;
  logic [BLOCK_WIDTH-1:0] key_q;
  logic                   decrypt_q;
  logic [CntWidth-1:0]    round_q;

  logic [CntWidth-1:0]    round_idx;
  logic [BLOCK_WIDTH-1:0] round_key;
  logic [BLOCK_WIDTH-1:0] enc_next;
  logic [BLOCK_WIDTH-1:0] dec_next;
  logic [BLOCK_WIDTH-1:0] round_out;

  // Rotate left by amt modulo the block width.
  function automatic logic [BLOCK_WIDTH-1:0] rotl(input logic [BLOCK_WIDTH-1:0] x,
                                                  input int unsigned amt);
    int unsigned s;
    s = amt % BLOCK_WIDTH;
    if (s == 0) begin
      return x;
    end
    return (x << s) | (x >> (BLOCK_WIDTH - s));
  endfunction

  // Rotate right by amt modulo the block width.
  function automatic logic [BLOCK_WIDTH-1:0] rotr(input logic [BLOCK_WIDTH-1:0] x,
                                                  input int unsigned amt);
    int unsigned s;
    s = amt % BLOCK_WIDTH;
    if (s == 0) begin
      return x;
    end
    return (x >> s) | (x << (BLOCK_WIDTH - s));
  endfunction

  // round_q always counts up from 0; decrypt maps it onto the descending round index so the
  // key schedule is consumed in reverse.
  always_comb begin
    round_idx = decrypt_q ? (LastRound - round_q) : round_q;
    round_key = rotl(key_q, 32'(round_idx));
    enc_next  = rotl(data_q ^ round_key, ROT_AMT);
    dec_next  = rotr(data_q, ROT_AMT) ^ round_key;
    round_out = decrypt_q ? dec_next : enc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_data    <= '0;
      data_q      <= '0;
      key_q       <= '0;
      decrypt_q   <= 1'b0;
      round_q     <= '0;
`ifdef CIPHER_BLOCK_COUNT_EN
      blocks_done <= 16'h0000;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q    <= in_data;
            key_q     <= in_key;
            decrypt_q <= in_decrypt;
            round_q   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StRun;
          end
        end

        StRun: begin
          data_q <= round_out;
          if (round_q == LastRound) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            round_q   <= '0;
            state_q   <= StDone;
          end else begin
            round_q <= round_q + CntWidth'(1);
          end
        end

        StDone: begin
          // in_ready stays low here so a new block cannot overwrite a pending result.
          if (out_ready) begin
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
`ifdef CIPHER_BLOCK_COUNT_EN
            blocks_done <= blocks_done + 16'h0001;
`endif
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          round_q   <= '0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_cipher_engine.sv
// Self-checking bench for iterative_cipher_engine: a default instance (4 rounds) and a
// single-round instance share data/key/mode/out_ready but have separate in_valid strobes.

module tb_iterative_cipher_engine;

  localparam int unsigned BW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned RA = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_valid1;
  logic [BW-1:0] in_data;
  logic [BW-1:0] in_key;
  logic          in_decrypt;
  logic          out_ready;

  logic          in_ready, out_valid, busy;
  logic [BW-1:0] out_data;
  logic          in_ready1, out_valid1, busy1;
  logic [BW-1:0] out_data1;
`ifdef CIPHER_BLOCK_COUNT_EN
  logic [15:0]   blocks_done;
  logic [15:0]   blocks_done1;
  int            exp_blocks = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iterative_cipher_engine #(
    .BLOCK_WIDTH(BW),
    .NUM_ROUNDS (NR),
    .ROT_AMT    (RA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_decrypt(in_decrypt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef CIPHER_BLOCK_COUNT_EN
    ,
    .blocks_done(blocks_done)
`endif
  );

  iterative_cipher_engine #(
    .BLOCK_WIDTH(BW),
    .NUM_ROUNDS (1),
    .ROT_AMT    (RA)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_decrypt(in_decrypt),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .busy      (busy1)
`ifdef CIPHER_BLOCK_COUNT_EN
    ,
    .blocks_done(blocks_done1)
`endif
  );

  // Reference model: rotation via a doubled word, rounds as a plain loop over the schedule.
  function automatic logic [BW-1:0] m_rotl(input logic [BW-1:0] x, input int s);
    logic [2*BW-1:0] d;
    d = {x, x} << (s % BW);
    return d[2*BW-1:BW];
  endfunction

  function automatic logic [BW-1:0] m_rotr(input logic [BW-1:0] x, input int s);
    return m_rotl(x, BW - (s % BW));
  endfunction

  function automatic logic [BW-1:0] model(input logic [BW-1:0] d, input logic [BW-1:0] k,
                                          input logic dec, input int n, input int rot);
    logic [BW-1:0] x;
    x = d;
    if (!dec) begin
      for (int r = 0; r < n; r++) x = m_rotl(x ^ m_rotl(k, r), rot);
    end else begin
      for (int r = n - 1; r >= 0; r--) x = m_rotr(x, rot) ^ m_rotl(k, r);
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic sel_ready(input int u);
    return (u != 0) ? in_ready1 : in_ready;
  endfunction
  function automatic logic sel_valid(input int u);
    return (u != 0) ? out_valid1 : out_valid;
  endfunction
  function automatic logic sel_busy(input int u);
    return (u != 0) ? busy1 : busy;
  endfunction
  function automatic logic [BW-1:0] sel_data(input int u);
    return (u != 0) ? out_data1 : out_data;
  endfunction

  // Offer one block to the chosen instance, check latency, then complete the handshake.
  task automatic run_block(input logic [BW-1:0] d, input logic [BW-1:0] k, input logic dec,
                           input int u, output logic [BW-1:0] res);
    int w;
    int lat;
    int n;
    n = (u != 0) ? 1 : NR;
    w = 0;
    while (!sel_ready(u) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_accept", 32'(sel_ready(u)), 32'd1);
    in_data    = d;
    in_key     = k;
    in_decrypt = dec;
    if (u != 0) in_valid1 = 1'b1;
    else        in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_valid1  = 1'b0;
    // Inputs changing after accept must not matter.
    in_data    = $urandom;
    in_key     = $urandom;
    in_decrypt = 1'($urandom);
    check("busy_after_accept", 32'({sel_ready(u), sel_busy(u)}), 32'b01);
    lat = 0;
    while (!sel_valid(u) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(n));
    res = sel_data(u);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_handshake", 32'({sel_valid(u), sel_ready(u), sel_busy(u)}), 32'b010);
`ifdef CIPHER_BLOCK_COUNT_EN
    if (u == 0) begin
      exp_blocks++;
      check("blocks_done", 32'(blocks_done), 32'(16'(exp_blocks)));
    end
`endif
  endtask

  typedef struct {
    logic [BW-1:0] data;
    logic [BW-1:0] key;
    logic          dec;
    logic [BW-1:0] exp;
  } vec_t;

  initial begin
    vec_t          vecs[7];
    logic [BW-1:0] res;
    logic [BW-1:0] res2;
    logic [BW-1:0] held;
    logic [BW-1:0] d;
    logic [BW-1:0] k;
    logic          dec;
    int            w;
    int            seen_valid;

    vecs[0] = '{32'h80000001, 32'h00000000, 1'b0, 32'h00000018};
    vecs[1] = '{32'h00000018, 32'h00000000, 1'b1, 32'h80000001};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
    vecs[4] = '{32'h00000000, 32'h00000001, 1'b0, 32'h00000000};
    vecs[5] = '{32'h00000000, 32'h00000001, 1'b1, 32'h00000000};
    vecs[6] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000010};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid1  = 1'b0;
    in_data    = '0;
    in_key     = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({in_ready, out_valid, busy}), 32'b100);
    check("reset_data", out_data, 32'h0);
    check("reset_flags_n1", 32'({in_ready1, out_valid1, busy1}), 32'b100);
`ifdef CIPHER_BLOCK_COUNT_EN
    check("reset_blocks_done", 32'(blocks_done), 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-round instance.
    run_block(32'h12345678, 32'hDEADBEEF, 1'b0, 1, res);
    check("n1_enc_vec", res, 32'h9933D12F);
    run_block(32'h80000001, 32'h00000000, 1'b0, 1, res);
    check("n1_enc_msb_lsb", res, 32'h00000003);
    for (int i = 0; i < 6; i++) begin
      d   = $urandom;
      k   = $urandom;
      dec = 1'($urandom);
      run_block(d, k, dec, 1, res);
      check("n1_random", res, model(d, k, dec, 1, RA));
    end

    // Known-answer table on the default instance.
    for (int i = 0; i < 7; i++) begin
      run_block(vecs[i].data, vecs[i].key, vecs[i].dec, 0, res);
      check($sformatf("table[%0d]", i), res, vecs[i].exp);
    end

    // Round trip.
    run_block(32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 0, res);
    check("roundtrip_enc", res, model(32'hCAFEF00D, 32'h0BADC0DE, 1'b0, NR, RA));
    run_block(res, 32'h0BADC0DE, 1'b1, 0, res2);
    check("roundtrip_dec", res2, 32'hCAFEF00D);

    // Random blocks against the model.
    for (int i = 0; i < 20; i++) begin
      d   = $urandom;
      k   = $urandom;
      dec = 1'($urandom);
      run_block(d, k, dec, 0, res);
      check("random", res, model(d, k, dec, NR, RA));
    end

    // Backpressure: result held, second block offered but not taken until the handshake.
    in_data    = 32'h01234567;
    in_key     = 32'h89ABCDEF;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_data    = 32'h76543210;
    in_key     = 32'hFEDCBA98;
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    held = out_data;
    check("bp_first_result", held, model(32'h01234567, 32'h89ABCDEF, 1'b0, NR, RA));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data, held);
      check("bp_hold_flags", 32'({in_ready, out_valid}), 32'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 32'({out_valid, in_ready, busy}), 32'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accept", 32'({in_ready, busy}), 32'b01);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_second_result", out_data, model(32'h76543210, 32'hFEDCBA98, 1'b0, NR, RA));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef CIPHER_BLOCK_COUNT_EN
    exp_blocks += 2;
    check("bp_blocks_done", 32'(blocks_done), 32'(16'(exp_blocks)));
`endif

    // Reset in the middle of a run.
    in_data  = 32'hA5A5A5A5;
    in_key   = 32'h5A5A5A5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_reset_flags", 32'({in_ready, out_valid, busy}), 32'b100);
    check("midrun_reset_data", out_data, 32'h0);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    check("midrun_no_output", 32'(seen_valid), 32'd0);
    run_block(32'h80000001, 32'h00000000, 1'b0, 0, res);
    check("after_reset_block", res, 32'h00000018);

`ifdef CIPHER_BLOCK_COUNT_EN
    // Reset cleared the counter; only the block above has completed since.
    exp_blocks = 1;
    run_block(32'h1, 32'h2, 1'b0, 0, res);
    run_block(32'h3, 32'h4, 1'b1, 0, res);
    check("count_three", 32'(blocks_done), 32'd3);
    force dut.blocks_done = 16'hFFFF;
    #1;
    release dut.blocks_done;
    exp_blocks = 16'hFFFF;
    run_block(32'h5, 32'h6, 1'b0, 0, res);
    check("count_wrap", 32'(blocks_done), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
